// File: rtl/vector_lsu_pkg.sv
// rtl/vector_lsu_pkg.sv - shared types and constants for the vector load/store unit
package vector_lsu_pkg;

  localparam int VLEN_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } lsu_state_t;

  typedef logic [VLEN_DEFAULT-1:0][VLEN_DEFAULT-1:0] lsu_vec_t;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_lsu_agen.sv
// rtl/vector_lsu_agen.sv - lane address generator; VECTOR_LSU_STRIDE_EN selects strided addressing
module vector_lsu_agen #(
  parameter int ADDR_W = 32,
  parameter int LANE_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
`ifdef VECTOR_LSU_STRIDE_EN
  input  logic [ADDR_W-1:0] stride_i,
`endif
  input  logic [LANE_W-1:0] lane_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] base_q;

`ifdef VECTOR_LSU_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q   <= '0;
      stride_q <= '0;
    end else if (load_i) begin
      base_q   <= base_i;
      stride_q <= stride_i;
    end
  end

  // Two's complement stride: truncating the product to ADDR_W gives the wrapped sum.
  assign addr_o = base_q + ADDR_W'(lane_i) * stride_q;
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
    end else if (load_i) begin
      base_q <= base_i;
    end
  end

  assign addr_o = base_q + ADDR_W'(lane_i);
`endif

endmodule

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - vector load/store unit sequencing lane transfers ahead of the vector RF write port
// Optional VECTOR_LSU_STRIDE_EN adds a stride_i operand for strided addressing.
module vector_lsu
  import vector_lsu_pkg::*;
#(
  parameter int WIDTH  = VLEN_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         is_store_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [4:0]                   vd_i,
  input  logic [WIDTH-1:0][WIDTH-1:0]  st_data_i,
`ifdef VECTOR_LSU_STRIDE_EN
  input  logic [ADDR_W-1:0]            stride_i,
`endif
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [WIDTH-1:0]             mem_wd_o,
  input  logic [WIDTH-1:0]             mem_rd_i,
  input  logic                         mem_ack_i,
  output logic                         wev_o,
  output logic [4:0]                   rd_o,
  output logic [WIDTH-1:0][WIDTH-1:0]  wd_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int LANE_W = lane_w(WIDTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WIDTH - 1);

  lsu_state_t                  state_q;
  logic [LANE_W-1:0]           lane_q;
  logic                        op_store_q;
  logic [4:0]                  vd_q;
  logic [WIDTH-1:0][WIDTH-1:0] st_q;
  logic [WIDTH-1:0][WIDTH-1:0] buf_q;
  logic [WIDTH-1:0][WIDTH-1:0] buf_d;
  logic [WIDTH-1:0][WIDTH-1:0] wd_q;
  logic [4:0]                  rd_q;
  logic                        mem_req_q;
  logic                        mem_we_q;
  logic                        wev_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        capture;
  logic                        lane_ack;

  assign capture  = (state_q == IDLE) && start_i;
  // Acks only count while a request is outstanding, i.e. in XFER.
  assign lane_ack = (state_q == XFER) && mem_ack_i;

  vector_lsu_agen #(
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_agen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (capture),
    .base_i   (base_addr_i),
`ifdef VECTOR_LSU_STRIDE_EN
    .stride_i (stride_i),
`endif
    .lane_i   (lane_q),
    .addr_o   (mem_addr_o)
  );

  always_comb begin
    buf_d = buf_q;
    if (lane_ack && !op_store_q) begin
      buf_d[lane_q] = mem_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      op_store_q <= 1'b0;
      vd_q       <= '0;
      st_q       <= '0;
      buf_q      <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      wev_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wev_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= XFER;
            lane_q     <= '0;
            op_store_q <= is_store_i;
            vd_q       <= vd_i;
            st_q       <= st_data_i;
            buf_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= is_store_i;
            busy_q     <= 1'b1;
          end
        end
        XFER: begin
          if (lane_ack) begin
            buf_q <= buf_d;
            if (lane_q == LAST_LANE) begin
              state_q   <= FIN;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
              // buf_d already holds the final lane, so WD is complete on the FIN cycle.
              if (!op_store_q) begin
                wev_q <= 1'b1;
                rd_q  <= vd_q;
                wd_q  <= buf_d;
              end
            end else begin
              lane_q <= lane_q + LANE_W'(1);
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;
  assign mem_wd_o  = st_q[lane_q];
  assign wev_o     = wev_q;
  assign rd_o      = rd_q;
  assign wd_o      = wd_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - self-checking bench for vector_lsu with a randomized memory responder
module tb_vector_lsu;
  localparam int W  = 16;
  localparam int AW = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i, start_i, is_store_i, mem_ack_i;
  logic [AW-1:0]        base_addr_i;
  logic [4:0]           vd_i;
  logic [W-1:0][W-1:0]  st_data_i;
  logic [W-1:0]         mem_rd_i;
`ifdef VECTOR_LSU_STRIDE_EN
  logic [AW-1:0]        stride_i;
`endif
  logic                 mem_req_o, mem_we_o, wev_o, busy_o, done_o;
  logic [AW-1:0]        mem_addr_o;
  logic [W-1:0]         mem_wd_o;
  logic [4:0]           rd_o;
  logic [W-1:0][W-1:0]  wd_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]        op_st [W];
  logic [W-1:0]        op_ld [W];
  int                  op_wait [W];
  logic [W-1:0][W-1:0] model_wd;
  logic [4:0]          model_rd;

  always #5 clk_i = ~clk_i;

  vector_lsu #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .is_store_i  (is_store_i),
    .base_addr_i (base_addr_i),
    .vd_i        (vd_i),
    .st_data_i   (st_data_i),
`ifdef VECTOR_LSU_STRIDE_EN
    .stride_i    (stride_i),
`endif
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i),
    .mem_ack_i   (mem_ack_i),
    .wev_o       (wev_o),
    .rd_o        (rd_o),
    .wd_o        (wd_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit check_hold);
    n_tests++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || wev_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b req=%b wev=%b done=%b, required all 0", tag, busy_o, mem_req_o, wev_o, done_o);
    end
    if (check_hold) begin
      n_tests++;
      if (wd_o !== model_wd || rd_o !== model_rd) begin
        n_fail++;
        $display("FAIL %s hold: rd=%0d wd=%h, required rd=%0d wd=%h", tag, rd_o, wd_o, model_rd, model_wd);
      end
    end
  endtask

  // One full operation; start2_at injects a competing start, rst_lane aborts on that lane.
  task automatic run_op(input bit st, input logic [AW-1:0] base, input logic [4:0] vd,
                        input logic [AW-1:0] stride, input int start2_at, input int rst_lane,
                        input string tag);
    int k, wc, t, exp_done;
    bit seen_done, aborted;
    logic [W-1:0][W-1:0] exp_wd;
    logic [AW-1:0] exp_addr;
    exp_done = 1;
    for (int i = 0; i < W; i++) begin
      exp_done += op_wait[i] + 1;
      exp_wd[i] = op_ld[i];
      st_data_i[i] = op_st[i];
    end
    for (int i = 0; i < 2; i++) begin
      mem_ack_i = 1'($urandom);
      mem_rd_i  = W'($urandom);
      step();
      check_idle({tag, "_pre"}, 1'b1);
    end
    start_i = 1'b1; is_store_i = st; base_addr_i = base; vd_i = vd; mem_ack_i = 1'b0;
`ifdef VECTOR_LSU_STRIDE_EN
    stride_i = stride;
`endif
    k = 0; wc = 0; t = 0; seen_done = 1'b0; aborted = 1'b0;
    while (!seen_done && !aborted && t < exp_done + 40) begin
      step();
      t++;
      start_i = 1'b0; rst_i = 1'b0; mem_ack_i = 1'b0; mem_rd_i = W'($urandom);
      if (t == start2_at) begin
        start_i = 1'b1; is_store_i = ~st; vd_i = 5'd3; base_addr_i = ~base;
      end
      if (done_o === 1'b1) begin
        seen_done = 1'b1;
        mem_ack_i = 1'($urandom);
        n_tests++;
        if (t !== exp_done) begin
          n_fail++;
          $display("FAIL %s latency: done at cycle %0d, required %0d", tag, t, exp_done);
        end
        n_tests++;
        if (wev_o !== !st || busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fin: wev=%b busy=%b req=%b, required wev=%b busy=1 req=0", tag, wev_o, busy_o, mem_req_o, !st);
        end
        if (!st) begin
          model_wd = exp_wd;
          model_rd = vd;
        end
        n_tests++;
        if (wd_o !== model_wd || rd_o !== model_rd) begin
          n_fail++;
          $display("FAIL %s rf_write: rd=%0d wd=%h, required rd=%0d wd=%h", tag, rd_o, wd_o, model_rd, model_wd);
        end
      end else if (k >= W) begin
        n_tests++; n_fail++;
        $display("FAIL %s overrun: no done after lane %0d, cycle %0d (required done at %0d)", tag, W - 1, t, exp_done);
        aborted = 1'b1;
      end else begin
        exp_addr = base + AW'(k) * stride;
        n_tests++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b1 || wev_o !== 1'b0 || mem_we_o !== st ||
            mem_addr_o !== exp_addr || (st && mem_wd_o !== op_st[k])) begin
          n_fail++;
          $display("FAIL %s lane %0d: busy=%b req=%b wev=%b we=%b addr=%h wd=%h, required 1 1 0 %b addr=%h wd=%h",
                   tag, k, busy_o, mem_req_o, wev_o, mem_we_o, mem_addr_o, mem_wd_o, st, exp_addr, op_st[k]);
        end
        if (k == rst_lane) begin
          rst_i = 1'b1;
          aborted = 1'b1;
        end else if (wc == op_wait[k]) begin
          mem_ack_i = 1'b1;
          mem_rd_i  = op_ld[k];
          k++;
          wc = 0;
        end else begin
          wc++;
        end
      end
    end
    if (!seen_done && !aborted) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles, required at %0d", tag, t, exp_done);
    end
    if (aborted && rst_i) begin
      model_wd = '0;
      model_rd = '0;
      step();
      rst_i = 1'b0;
      check_idle({tag, "_abort"}, 1'b1);
      for (int i = 0; i < 20; i++) begin
        mem_ack_i = 1'($urandom);
        step();
        check_idle({tag, "_after_abort"}, 1'b1);
      end
    end else begin
      step();
      start_i = 1'b0;
      mem_ack_i = 1'b0;
      check_idle({tag, "_post"}, 1'b1);
    end
    rst_i = 1'b0;
  endtask

  task automatic fill(input int maxwait);
    for (int i = 0; i < W; i++) begin
      op_st[i]   = W'($urandom);
      op_ld[i]   = W'($urandom);
      op_wait[i] = $urandom_range(0, maxwait);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; is_store_i = 1'b0; base_addr_i = 32'h1234; vd_i = 5'd7;
    st_data_i = '1; mem_ack_i = 1'b1; mem_rd_i = '1;
`ifdef VECTOR_LSU_STRIDE_EN
    stride_i = 32'd1;
`endif
    model_wd = '0;
    model_rd = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle("reset", 1'b1);
      n_tests++;
      if (mem_addr_o !== '0 || mem_we_o !== 1'b0 || mem_wd_o !== '0) begin
        n_fail++;
        $display("FAIL reset mem: addr=%h we=%b wd=%h, required 0", mem_addr_o, mem_we_o, mem_wd_o);
      end
    end
    rst_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b0;
    step();
    check_idle("reset_release", 1'b1);
  endtask

  task automatic test_load_zero_wait();
    for (int i = 0; i < W; i++) begin
      op_ld[i] = 16'hCCCC + W'(i); op_st[i] = '0; op_wait[i] = 0;
    end
    run_op(1'b0, 32'h100, 5'd1, 32'd1, -1, -1, "load_zero_wait");
  endtask

  task automatic test_store_waits();
    for (int i = 0; i < W; i++) begin
      op_st[i] = 16'hA5A5; op_ld[i] = W'($urandom); op_wait[i] = 2;
    end
    run_op(1'b1, 32'h200, 5'd4, 32'd1, -1, -1, "store_waits");
  endtask

  task automatic test_busy_ignore();
    fill(1);
    run_op(1'b0, 32'h300, 5'd9, 32'd1, 5, -1, "busy_ignore");
    fill(0);
    run_op(1'b0, 32'h380, 5'd12, 32'd1, W + 1, -1, "start_in_fin");
  endtask

  task automatic test_reset_mid_op();
    fill(1);
    run_op(1'b0, 32'h400, 5'd6, 32'd1, -1, 7, "reset_mid_op");
  endtask

  task automatic test_addr_wrap();
    fill(1);
    run_op(1'b0, 32'hFFFF_FFF8, 5'd0, 32'd1, -1, -1, "addr_wrap");
  endtask

`ifdef VECTOR_LSU_STRIDE_EN
  task automatic test_stride();
    fill(1);
    run_op(1'b0, 32'h40, 5'd2, 32'hFFFF_FFFE, -1, -1, "stride_neg2");
    fill(0);
    run_op(1'b1, 32'h80, 5'd2, 32'd0, -1, -1, "stride_zero");
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] s;
    for (int n = 0; n < 8; n++) begin
      fill(3);
      s = 32'd1;
`ifdef VECTOR_LSU_STRIDE_EN
      s = 32'($urandom_range(0, 8)) - 32'd4;
`endif
      run_op(1'($urandom), 32'($urandom), 5'($urandom), s,
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_waits();
    test_busy_ignore();
    test_reset_mid_op();
    test_addr_wrap();
`ifdef VECTOR_LSU_STRIDE_EN
    test_stride();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
- Vector load/store unit sitting directly upstream of vectorial_rf on its write port.
- Loads move WIDTH lanes from data memory, one lane per accepted transfer, into a staging buffer, then write the full vector with one WEV/RD/WD pulse.
- Stores take a vector read from the register file (RD1 output) and write it to memory lane by lane.
- Sequenced by an FSM with a lane counter and a req/ack memory handshake.

Parameters:
- WIDTH, 16, lane width in bits and lane count. It must match vectorial_rf WIDTH.
- ADDR_W, 32, memory address width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle op request, honoured only in IDLE.
- is_store  input  1  sampled with start: 1 = store, 0 = load.
- base_addr  input  ADDR_W  lane 0 address, sampled with start.
- vd  input  5  destination vector register for loads, sampled with start.
- st_data  input  WIDTH*WIDTH (packed [WIDTH-1:0][WIDTH-1:0])  store vector, sampled with start.
- mem_req  output  1  memory transfer request.
- mem_we  output  1  1 = write transfer.
- mem_addr  output  ADDR_W  transfer address.
- mem_wd  output  WIDTH  store lane data.
- mem_rd  input  WIDTH  load lane data, valid when mem_ack=1.
- mem_ack  input  1  transfer complete this cycle.
- WEV  output  1  register-file write enable.
- RD  output  5  register-file destination.
- WD  output  WIDTH*WIDTH (packed)  register-file write vector.
- busy  output  1  op in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, lane=0. All outputs, the staging buffer and the captured operands are 0.
- States: IDLE, XFER, FIN.
- IDLE:
  - busy=0, mem_req=0.
  - On start=1, capture is_store, base_addr, vd and st_data, set lane=0, and go to XFER next cycle.
- XFER:
  - busy=1, mem_req=1, mem_we=op_is_store.
  - mem_addr = base + lane (mod 2^ADDR_W, so wrap-around is silent).
  - mem_wd = st_data lane[lane], where lane i = bits [i*WIDTH +: WIDTH].
  - mem_req, mem_addr, mem_we and mem_wd stay stable until mem_ack.
  - On mem_ack for a load, buf lane[lane] <= mem_rd.
  - On mem_ack with lane < WIDTH-1, lane++.
  - On mem_ack with lane = WIDTH-1, go to FIN.
- FIN, exactly one cycle:
  - busy=1, done=1, mem_req=0.
  - Load: WEV=1, RD=captured vd, WD=buf.
  - Store: WEV=0.
  - Next state IDLE.
- Latency with zero-wait memory (ack every cycle):
  - start at cycle 0 → lanes transfer in cycles 1..WIDTH → FIN (WEV/done) at cycle WIDTH+1.
  - Each wait cycle (req=1, ack=0) adds one cycle.
- WEV is never asserted outside FIN. WD and RD hold their last values outside FIN.
- start in XFER or FIN is ignored; no queueing.
- mem_ack while mem_req=0 is ignored.
- rst mid-op returns to IDLE next cycle. No WEV and no done for the aborted op; the partial buffer is cleared.
- Loads to vd=0 still write. The register file decides semantics.

Optional Feature:
- Macro VECTOR_LSU_STRIDE_EN.
- Defined:
  - Adds input stride (ADDR_W, two's complement), sampled with start.
  - mem_addr = base + lane*stride (mod 2^ADDR_W).
  - stride=0 is legal: every lane uses the same address.
- Undefined:
  - No stride port; unit stride fixed (mem_addr = base + lane).

Decomposition:
- Package vector_lsu_pkg:
  - localparam VLEN_DEFAULT=16.
  - typedef enum logic [1:0] {IDLE, XFER, FIN} lsu_state_t.
  - typedef for the packed vector, logic [WIDTH-1:0][WIDTH-1:0], via a parameterised macro or a 16-default typedef.
- One sub-module, vector_lsu_agen: registered base/stride, lane-counter input, and combinational mem_addr. It isolates the stride macro.

Test Plan:
- Reset: hold rst=1 for 2 cycles while start=1 → busy=0, mem_req=0, WEV=0, done=0, WD=0.
- Load, zero-wait: base=0x100, vd=1; memory returns 0xCCCC+lane with ack every cycle → mem_addr runs 0x100..0x10F in cycles 1..16. In cycle 17, WEV=1, RD=1, WD lane i = 0xCCCC+i, done=1. vectorial_rf then reads RD1 equal to that vector.
- Store with waits: st_data all 16'hA5A5, base=0x200; ack delayed 2 cycles per lane → each address held 3 cycles with mem_we=1 and mem_wd=0xA5A5. done arrives at cycle 49. WEV stays 0.
- Busy ignore: a second start at cycle 5 of a load (different vd=3) → no effect; the single WEV carries RD=original vd.
- Reset mid-op: assert rst on lane 7 of a load → next cycle IDLE, mem_req=0; no WEV or done is ever seen for that op.
- Address wrap: base=0xFFFF_FFF8 → lanes 8..15 use addresses 0x0..0x7.
- With VECTOR_LSU_STRIDE_EN, stride=-2 and base=0x40 → addresses 0x40, 0x3E, …, 0x22.
